// File: rtl/game2048_pkg.sv
// Shared definitions for the 2048 move engine: move directions, FSM encoding
// and the board tile-offset helper.
package game2048_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit offset of tile (r,c); tile (0,0) occupies the most significant bits.
    function automatic int tile_off(input int r, input int c, input int n, input int tw);
        return (n * n - 1 - (r * n + c)) * tw;
    endfunction

endpackage

// File: rtl/board_move_engine_if.sv
// Start/done handshake and board bus between the game controller (master)
// and the move engine (slave).
interface board_move_engine_if #(
    parameter int N       = 4,
    parameter int TW      = 4,
    parameter int SCORE_W = 20
);
    localparam int MW = $clog2(N * N / 2 + 1);

    logic                  start;
    logic [1:0]            dir;
    logic [N*N*TW-1:0]     board_in;
    logic                  busy;
    logic                  done;
    logic [N*N*TW-1:0]     board_out;
    logic                  moved;
    logic [MW-1:0]         merges;
    logic [SCORE_W-1:0]    score_inc;

    modport master (
        output start, dir, board_in,
        input  busy, done, board_out, moved, merges, score_inc
    );

    modport slave (
        input  start, dir, board_in,
        output busy, done, board_out, moved, merges, score_inc
    );

endinterface

// File: rtl/line_merge.sv
// Combinational 2048 line rule: compact toward index 0, merge equal pairs once
// each (max exponent never merges), zero-fill; also reports merges and score.
module line_merge #(
    parameter int N  = 4,
    parameter int TW = 4,
    localparam int LM_W = $clog2(N / 2 + 1),
    localparam int LS_W = (1 << TW) + $clog2(N)
) (
    input  logic [N-1:0][TW-1:0] line_in,
    output logic [N-1:0][TW-1:0] line_out,
    output logic [LM_W-1:0]      line_merges,
    output logic [LS_W-1:0]      line_score
);
    localparam int CW = $clog2(N + 1);
    localparam logic [TW-1:0] TILE_MAX = {TW{1'b1}};

    // Extra trailing slot lets the pair scan read index i+1 without a range guard.
    logic [TW-1:0] comp_s [0:N];
    logic [TW-1:0] out_s  [0:N];
    logic [CW-1:0] cnt_s;
    logic [CW-1:0] wr_s;
    logic          skip_s;

    // Compact, pair-merge and zero-fill in a single pass.
    always_comb begin
        for (int i = 0; i <= N; i++) begin
            comp_s[i] = {TW{1'b0}};
            out_s[i]  = {TW{1'b0}};
        end
        cnt_s       = {CW{1'b0}};
        wr_s        = {CW{1'b0}};
        skip_s      = 1'b0;
        line_merges = {LM_W{1'b0}};
        line_score  = {LS_W{1'b0}};

        for (int i = 0; i < N; i++) begin
            if (line_in[i] != {TW{1'b0}}) begin
                comp_s[cnt_s] = line_in[i];
                cnt_s         = cnt_s + CW'(1);
            end else begin
                cnt_s = cnt_s;
            end
        end

        for (int i = 0; i < N; i++) begin
            if (skip_s) begin
                skip_s = 1'b0;
            end else if (comp_s[i] != {TW{1'b0}} && comp_s[i] == comp_s[i+1]
                         && comp_s[i] != TILE_MAX) begin
                out_s[wr_s] = comp_s[i] + {{(TW-1){1'b0}}, 1'b1};
                wr_s        = wr_s + CW'(1);
                line_merges = line_merges + LM_W'(1);
                line_score  = line_score
                            + ({{(LS_W-1){1'b0}}, 1'b1} << (comp_s[i] + {{(TW-1){1'b0}}, 1'b1}));
                skip_s      = 1'b1;
            end else if (comp_s[i] != {TW{1'b0}}) begin
                out_s[wr_s] = comp_s[i];
                wr_s        = wr_s + CW'(1);
            end else begin
                skip_s = 1'b0;
            end
        end

        for (int i = 0; i < N; i++) begin
            line_out[i] = out_s[i];
        end
    end

endmodule

// File: rtl/board_move_engine.sv
// Sequential NxN 2048 move engine: one board line per clock through a shared
// line_merge, with merge count and saturating score accumulation.
module board_move_engine
    import game2048_pkg::*;
#(
    parameter int N       = 4,
    parameter int TW      = 4,
    parameter int SCORE_W = 20
) (
    input  logic                clk,
    input  logic                rst,
    board_move_engine_if.slave  bus
);
    localparam int BW    = N * N * TW;
    localparam int OFF_W = $clog2(BW);
    localparam int MW    = $clog2(N * N / 2 + 1);
    localparam int LM_W  = $clog2(N / 2 + 1);
    localparam int LS_W  = (1 << TW) + $clog2(N);
    localparam int LI_W  = $clog2(N);
    localparam int SUM_W = SCORE_W + LS_W;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [LI_W-1:0]    LAST_LINE = LI_W'(N - 1);

    state_t              state_r;
    logic [1:0]          dir_r;
    logic [LI_W-1:0]     line_idx_r;
    logic [BW-1:0]       work_r;
    logic [BW-1:0]       orig_r;
    logic                busy_r;
    logic                done_r;
    logic                moved_r;
    logic [MW-1:0]       merges_r;
    logic [SCORE_W-1:0]  score_r;

    logic [N-1:0][TW-1:0] line_s;
    logic [N-1:0][TW-1:0] merged_s;
    logic [LM_W-1:0]      line_merges_s;
    logic [LS_W-1:0]      line_score_s;
    logic [BW-1:0]        next_board_s;
    logic [SUM_W-1:0]     score_sum_s;
    logic [SCORE_W-1:0]   score_sat_s;

    // Element k of line l sits k tiles away from the destination wall.
    function automatic int lane_off(input logic [1:0] d, input int l, input int k);
        int off;
        case (d)
            DIR_UP:    off = tile_off(k, l, N, TW);
            DIR_DOWN:  off = tile_off(N - 1 - k, l, N, TW);
            DIR_LEFT:  off = tile_off(l, k, N, TW);
            DIR_RIGHT: off = tile_off(l, N - 1 - k, N, TW);
            default:   off = tile_off(l, k, N, TW);
        endcase
        return off;
    endfunction

    // Gather the current line from the working board in wall-first order.
    always_comb begin
        line_s = '0;
        for (int k = 0; k < N; k++) begin
            line_s[k] = work_r[OFF_W'(lane_off(dir_r, int'(line_idx_r), k)) +: TW];
        end
    end

    line_merge #(.N(N), .TW(TW)) u_line_merge (
        .line_in     (line_s),
        .line_out    (merged_s),
        .line_merges (line_merges_s),
        .line_score  (line_score_s)
    );

    // Scatter the merged line back into a copy of the working board.
    always_comb begin
        next_board_s = work_r;
        for (int k = 0; k < N; k++) begin
            next_board_s[OFF_W'(lane_off(dir_r, int'(line_idx_r), k)) +: TW] = merged_s[k];
        end
    end

    // Saturating score accumulation on a widened sum.
    always_comb begin
        score_sum_s = SUM_W'(score_r) + SUM_W'(line_score_s);
        if (score_sum_s > SUM_W'(SCORE_MAX)) begin
            score_sat_s = SCORE_MAX;
        end else begin
            score_sat_s = score_sum_s[SCORE_W-1:0];
        end
    end

    // Move FSM with line counter, working board and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            dir_r      <= DIR_UP;
            line_idx_r <= {LI_W{1'b0}};
            work_r     <= {BW{1'b0}};
            orig_r     <= {BW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            moved_r    <= 1'b0;
            merges_r   <= {MW{1'b0}};
            score_r    <= {SCORE_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r    <= ST_RUN;
                        busy_r     <= 1'b1;
                        dir_r      <= bus.dir;
                        work_r     <= bus.board_in;
                        orig_r     <= bus.board_in;
                        line_idx_r <= {LI_W{1'b0}};
                        moved_r    <= 1'b0;
                        merges_r   <= {MW{1'b0}};
                        score_r    <= {SCORE_W{1'b0}};
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    work_r     <= next_board_s;
                    merges_r   <= merges_r + MW'(line_merges_s);
                    score_r    <= score_sat_s;
                    line_idx_r <= line_idx_r + LI_W'(1);
                    if (line_idx_r == LAST_LINE) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        moved_r <= (next_board_s != orig_r);
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.board_out = work_r;
    assign bus.moved     = moved_r;
    assign bus.merges    = merges_r;
    assign bus.score_inc = score_r;

endmodule

// File: tb/tb_board_move_engine.sv
// Directed self-checking bench for board_move_engine (N=4, TW=4, SCORE_W=20);
// boards are written as hex digits in row-major order.
module tb_board_move_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    board_move_engine_if #(.N(4), .TW(4), .SCORE_W(20)) bus ();

    board_move_engine #(.N(4), .TW(4), .SCORE_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one move, time the done pulse and check all results against hand values.
    task automatic run_move(input string tag, input logic [63:0] b, input logic [1:0] d,
                            input logic [63:0] exp_b, input logic exp_moved,
                            input logic [3:0] exp_m, input logic [19:0] exp_s);
        int cyc;
        @(negedge clk);
        bus.board_in = b;
        bus.dir      = d;
        bus.start    = 1'b1;
        @(negedge clk);
        cyc          = 1;
        bus.start    = 1'b0;
        bus.board_in = ~b;
        bus.dir      = ~d;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 64'(bus.done), 64'd1);
        check({tag, "_done_cycle"}, 64'(cyc), 64'd5);
        check({tag, "_board"}, bus.board_out, exp_b);
        check({tag, "_moved"}, 64'(bus.moved), 64'(exp_moved));
        check({tag, "_merges"}, 64'(bus.merges), 64'(exp_m));
        check({tag, "_score"}, 64'(bus.score_inc), 64'(exp_s));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        check({tag, "_hold_board"}, bus.board_out, exp_b);
    endtask

    initial begin
        int ndone;
        bus.start    = 1'b0;
        bus.dir      = 2'd0;
        bus.board_in = 64'h0;

        repeat (2) @(negedge clk);
        check("rst_busy",  64'(bus.busy), 64'd0);
        check("rst_done",  64'(bus.done), 64'd0);
        check("rst_board", bus.board_out, 64'h0);
        check("rst_moved", 64'(bus.moved), 64'd0);
        check("rst_merges", 64'(bus.merges), 64'd0);
        check("rst_score", 64'(bus.score_inc), 64'd0);
        rst = 1'b0;

        run_move("t1_quad",  64'h1111_0000_0000_0000, 2'd2, 64'h2200_0000_0000_0000, 1'b1, 4'd2, 20'd8);
        run_move("t2_nochain", 64'h2023_0000_0000_0000, 2'd2, 64'h3300_0000_0000_0000, 1'b1, 4'd1, 20'd8);
        run_move("t3_up",    64'h0000_1000_0000_1000, 2'd0, 64'h2000_0000_0000_0000, 1'b1, 4'd1, 20'd4);
        run_move("t_right",  64'h1120_0000_0000_0000, 2'd3, 64'h0022_0000_0000_0000, 1'b1, 4'd1, 20'd4);
        run_move("t_down",   64'h0300_0300_0300_0000, 2'd1, 64'h0000_0000_0300_0400, 1'b1, 4'd1, 20'd16);
        for (int d = 0; d < 4; d++) begin
            run_move("t4_checker", 64'h1212_2121_1212_2121, 2'(d), 64'h1212_2121_1212_2121, 1'b0, 4'd0, 20'd0);
        end
        run_move("t5_sat_left",  64'hFF00_0000_0000_0000, 2'd2, 64'hFF00_0000_0000_0000, 1'b0, 4'd0, 20'd0);
        run_move("t5_sat_right", 64'hFF00_0000_0000_0000, 2'd3, 64'h00FF_0000_0000_0000, 1'b1, 4'd0, 20'd0);

        // start re-pulsed mid-move with a different board and dir must be ignored.
        @(negedge clk);
        bus.board_in = 64'h1111_0000_0000_0000;
        bus.dir      = 2'd2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.board_in = 64'h0000_0000_0000_1111;
        bus.dir      = 2'd3;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                ndone++;
                check("t6_ign_board", bus.board_out, 64'h2200_0000_0000_0000);
                check("t6_ign_merges", 64'(bus.merges), 64'd2);
            end
            @(negedge clk);
        end
        check("t6_one_done", 64'(ndone), 64'd1);

        // Reset asserted during RUN cycle 2 aborts the move.
        bus.board_in = 64'h1111_0000_0000_0000;
        bus.dir      = 2'd2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy",  64'(bus.busy), 64'd0);
        check("t6_rst_board", bus.board_out, 64'h0);
        check("t6_rst_done",  64'(bus.done), 64'd0);
        check("t6_rst_merges", 64'(bus.merges), 64'd0);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("t6_rst_no_done", 64'(ndone), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
